// File: rtl/reg_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// reg_wb_arbiter_pkg
// Shared definitions for the register-file writeback arbiter.
//   DEF_W / DEF_D : default data width and register address width
//   req_id_e      : requester index, REQ_A (ALU writeback) / REQ_B (load unit)
//   wb_slot_t     : one holding-slot entry {valid, addr, data} at default widths
//   other_req()   : the requester that is not the given one
// -----------------------------------------------------------------------------
package reg_wb_arbiter_pkg;

    localparam int DEF_W = 8;
    localparam int DEF_D = 4;

    // Numeric values double as slot indices inside the arbiter (A = 0, B = 1).
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    // Default-width view of a holding slot. Parameterised instances use a
    // same-shaped local typedef built from their own W and D.
    typedef struct packed {
        logic             valid;
        logic [DEF_D-1:0] addr;
        logic [DEF_W-1:0] data;
    } wb_slot_t;

    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/reg_wb_arbiter_wb_slot.sv
// -----------------------------------------------------------------------------
// wb_slot
// One-entry holding register for a single writeback requester.
//   CLK, RST_N          : clock, asynchronous active-low reset (slot empties)
//   load                : capture load_addr/load_data and mark the slot valid
//   clear               : drop the entry (ignored when load is also high, so a
//                         granted slot can be refilled on the same edge)
//   load_addr/load_data : incoming entry
//   valid/addr/data     : current slot contents
// -----------------------------------------------------------------------------
module wb_slot
    import reg_wb_arbiter_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int D = DEF_D
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         load,
    input  logic         clear,
    input  logic [D-1:0] load_addr,
    input  logic [W-1:0] load_data,
    output logic         valid,
    output logic [D-1:0] addr,
    output logic [W-1:0] data
);

    typedef struct packed {
        logic         valid;
        logic [D-1:0] addr;
        logic [W-1:0] data;
    } slot_t;

    slot_t slot_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            slot_reg <= '0;
        end else if (load) begin
            slot_reg.valid <= 1'b1;
            slot_reg.addr  <= load_addr;
            slot_reg.data  <= load_data;
        end else if (clear) begin
            // Address/data are left stale; consumers qualify them with valid.
            slot_reg.valid <= 1'b0;
        end
    end

    assign valid = slot_reg.valid;
    assign addr  = slot_reg.addr;
    assign data  = slot_reg.data;

endmodule

// File: rtl/reg_wb_arbiter.sv
// -----------------------------------------------------------------------------
// reg_wb_arbiter
// Arbitrates two writeback requesters (A = ALU, B = load unit) onto the single
// write port of the register file. Each requester has a one-entry holding
// slot; grants are combinational from the slots, so a request accepted on
// edge N is written at the earliest on edge N+1.
//   CLK, RST_N                     : clock, asynchronous active-low reset
//   a_valid/a_ready/a_addr/a_data  : requester A valid/ready write offer
//   b_valid/b_ready/b_addr/b_data  : requester B valid/ready write offer
//   wr_hold                        : suppress any grant this cycle
//   reg_we/reg_waddr/reg_wdata     : register-file write port (zero when idle)
//   pend_mask                      : one bit per register with a buffered write
// Policy: a lone valid slot is granted at once; two valid slots with different
// addresses follow a round-robin pointer; two slots hitting the same address
// are drained oldest first so the younger value lands last. Writes to
// register 0 are dropped at acceptance.
// -----------------------------------------------------------------------------
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int D = DEF_D
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [D-1:0]    a_addr,
    input  logic [W-1:0]    a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [D-1:0]    b_addr,
    input  logic [W-1:0]    b_data,
    input  logic            wr_hold,
    output logic            reg_we,
    output logic [D-1:0]    reg_waddr,
    output logic [W-1:0]    reg_wdata,
    output logic [2**D-1:0] pend_mask
);

    localparam int NREQ = 2;

    // Index 0 is requester A, index 1 is requester B (matches req_id_e).
    logic [NREQ-1:0] req_valid;
    logic [D-1:0]    req_addr  [NREQ];
    logic [W-1:0]    req_data  [NREQ];

    logic [NREQ-1:0] slot_valid;
    logic [D-1:0]    slot_addr [NREQ];
    logic [W-1:0]    slot_data [NREQ];

    logic [NREQ-1:0] slot_ready;
    logic [NREQ-1:0] slot_load;
    logic [NREQ-1:0] slot_grant;
    logic [NREQ-1:0] slot_keep;

    logic            grant_en;
    req_id_e         grant_id;

    // Round-robin pointer: requester favoured when both slots differ in address.
    req_id_e         ptr_reg;
    // High when slot A holds the older entry; only meaningful with both valid.
    logic            a_older_reg;

    assign req_valid   = {b_valid, a_valid};
    assign req_addr[0] = a_addr;
    assign req_addr[1] = b_addr;
    assign req_data[0] = a_data;
    assign req_data[1] = b_data;

    // -------------------------------------------------------------------------
    // Per-requester slot plus its handshake.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
        // A granted slot frees up on this edge, so it can take a new entry.
        assign slot_ready[gi] = !slot_valid[gi] || slot_grant[gi];
        // Register 0 reads as zero: accept the handshake but store nothing.
        assign slot_load[gi]  = req_valid[gi] && slot_ready[gi] &&
                                (req_addr[gi] != '0);
        // Entry already held that is still there after this edge.
        assign slot_keep[gi]  = slot_valid[gi] && !slot_grant[gi];

        wb_slot #(
            .W(W),
            .D(D)
        ) u_slot (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .load      (slot_load[gi]),
            .clear     (slot_grant[gi]),
            .load_addr (req_addr[gi]),
            .load_data (req_data[gi]),
            .valid     (slot_valid[gi]),
            .addr      (slot_addr[gi]),
            .data      (slot_data[gi])
        );
    end

    assign a_ready = slot_ready[0];
    assign b_ready = slot_ready[1];

    // -------------------------------------------------------------------------
    // Grant selection.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_en = 1'b0;
        grant_id = REQ_A;
        if (!wr_hold) begin
            if (slot_valid[0] && slot_valid[1]) begin
                grant_en = 1'b1;
                if (slot_addr[0] == slot_addr[1]) begin
                    // Same destination: retire the older value first so the
                    // register ends up holding the younger one.
                    grant_id = a_older_reg ? REQ_A : REQ_B;
                end else begin
                    grant_id = ptr_reg;
                end
            end else if (slot_valid[0]) begin
                grant_en = 1'b1;
                grant_id = REQ_A;
            end else if (slot_valid[1]) begin
                grant_en = 1'b1;
                grant_id = REQ_B;
            end
        end
    end

    assign slot_grant[0] = grant_en && (grant_id == REQ_A);
    assign slot_grant[1] = grant_en && (grant_id == REQ_B);

    // -------------------------------------------------------------------------
    // Pointer and age tracking.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_reg     <= REQ_A;
            a_older_reg <= 1'b1;
        end else begin
            if (grant_en) begin
                ptr_reg <= other_req(grant_id);
            end
            // A newly loaded entry is younger than whatever survives in the
            // other slot; simultaneous loads make A the older one.
            if (slot_load[0] && slot_load[1]) begin
                a_older_reg <= 1'b1;
            end else if (slot_load[0]) begin
                a_older_reg <= !slot_keep[1];
            end else if (slot_load[1]) begin
                a_older_reg <= slot_keep[0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Register-file write port, zeroed when no grant is issued.
    // -------------------------------------------------------------------------
    always_comb begin
        reg_we    = grant_en;
        reg_waddr = '0;
        reg_wdata = '0;
        if (slot_grant[0]) begin
            reg_waddr = slot_addr[0];
            reg_wdata = slot_data[0];
        end else if (slot_grant[1]) begin
            reg_waddr = slot_addr[1];
            reg_wdata = slot_data[1];
        end
    end

    // -------------------------------------------------------------------------
    // Pending-write mask: one-hot of every valid slot address. A granted slot
    // keeps its bit until the edge that empties it.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 2**D; gi++) begin : g_pend
        assign pend_mask[gi] = (slot_valid[0] && (slot_addr[0] == D'(gi))) ||
                               (slot_valid[1] && (slot_addr[1] == D'(gi)));
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;

    localparam int W = 8;
    localparam int D = 4;
    localparam int N = 16;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         a_valid = 1'b0;
    logic         a_ready;
    logic [D-1:0] a_addr = '0;
    logic [W-1:0] a_data = '0;
    logic         b_valid = 1'b0;
    logic         b_ready;
    logic [D-1:0] b_addr = '0;
    logic [W-1:0] b_data = '0;
    logic         wr_hold = 1'b0;
    logic         reg_we;
    logic [D-1:0] reg_waddr;
    logic [W-1:0] reg_wdata;
    logic [N-1:0] pend_mask;

    always #5 CLK = ~CLK;

    reg_wb_arbiter #(.W(W), .D(D)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .wr_hold   (wr_hold),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .pend_mask (pend_mask)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Register file as seen through the DUT's write port.
    logic [W-1:0] rf_obs [N];

    // ---------------- reference model (timestamp based) ----------------
    logic         m_v     [2];
    logic [D-1:0] m_a     [2];
    logic [W-1:0] m_d     [2];
    int           m_stamp [2];
    int           m_last;      // port granted most recently; the other one is favoured
    int           m_seq;
    logic [W-1:0] m_rf    [N];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 1'b0; m_a[k] = '0; m_d[k] = '0; m_stamp[k] = 0;
        end
        m_last = 1;
        m_seq  = 0;
    endtask

    // -1: no grant, 0: A, 1: B
    function automatic int m_grant(input logic hold);
        if (hold) return -1;
        if (m_v[0] && m_v[1]) begin
            if (m_a[0] == m_a[1]) return (m_stamp[0] < m_stamp[1]) ? 0 : 1;
            return 1 - m_last;
        end
        if (m_v[0]) return 0;
        if (m_v[1]) return 1;
        return -1;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic av, input logic [D-1:0] aa, input logic [W-1:0] ad,
                         input logic bv, input logic [D-1:0] ba, input logic [W-1:0] bd,
                         input logic hold);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        wr_hold = hold;
    endtask

    task automatic check_outs(input string tag, input logic ar, input logic br, input logic we,
                              input logic [D-1:0] wa, input logic [W-1:0] wd, input logic [N-1:0] pm);
        check($sformatf("%s.a_ready", tag),   32'(a_ready),   32'(ar));
        check($sformatf("%s.b_ready", tag),   32'(b_ready),   32'(br));
        check($sformatf("%s.reg_we", tag),    32'(reg_we),    32'(we));
        check($sformatf("%s.reg_waddr", tag), 32'(reg_waddr), 32'(wa));
        check($sformatf("%s.reg_wdata", tag), 32'(reg_wdata), 32'(wd));
        check($sformatf("%s.pend_mask", tag), 32'(pend_mask), 32'(pm));
    endtask

    // Called #1 after a falling edge: record any write, then advance to the next falling edge.
    task automatic finish_cycle();
        if (reg_we === 1'b1) rf_obs[reg_waddr] = reg_wdata;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic cyc(input string tag,
                       input logic av, input logic [D-1:0] aa, input logic [W-1:0] ad,
                       input logic bv, input logic [D-1:0] ba, input logic [W-1:0] bd,
                       input logic hold,
                       input logic ar, input logic br, input logic we,
                       input logic [D-1:0] wa, input logic [W-1:0] wd, input logic [N-1:0] pm);
        drive(av, aa, ad, bv, ba, bd, hold);
        #1;
        check_outs(tag, ar, br, we, wa, wd, pm);
        $display("%s: a=%0b/%0h/%0h b=%0b/%0h/%0h hold=%0b -> we=%0b waddr=%0h wdata=%0h pend=%04h",
                 tag, av, aa, ad, bv, ba, bd, hold, reg_we, reg_waddr, reg_wdata, pend_mask);
        finish_cycle();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         av; logic [D-1:0] aa; logic [W-1:0] ad;
        logic         bv; logic [D-1:0] ba; logic [W-1:0] bd;
        logic         hold;
        logic         ar; logic br; logic we;
        logic [D-1:0] wa; logic [W-1:0] wd; logic [N-1:0] pm;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic av, input logic [D-1:0] aa, input logic [W-1:0] ad,
                                input logic bv, input logic [D-1:0] ba, input logic [W-1:0] bd,
                                input logic hold,
                                input logic ar, input logic br, input logic we,
                                input logic [D-1:0] wa, input logic [W-1:0] wd, input logic [N-1:0] pm);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd; v.hold = hold;
        v.ar = ar; v.br = br; v.we = we; v.wa = wa; v.wd = wd; v.pm = pm;
        return v;
    endfunction

    initial begin
        // A single write to register 3, one cycle of latency
        vecs[0]  = mk(1, 3, 8'h5A, 0, 0, 8'h00, 0,  1, 1, 0, 0, 8'h00, 16'h0000);
        vecs[1]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  1, 1, 1, 3, 8'h5A, 16'h0008);
        vecs[2]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  1, 1, 0, 0, 8'h00, 16'h0000);
        // B write moves the pointer back to A; A offers register 0 (discarded)
        vecs[3]  = mk(0, 0, 8'h00, 1, 6, 8'h66, 0,  1, 1, 0, 0, 8'h00, 16'h0000);
        vecs[4]  = mk(1, 0, 8'hFF, 0, 0, 8'h00, 0,  1, 1, 1, 6, 8'h66, 16'h0040);
        vecs[5]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  1, 1, 0, 0, 8'h00, 16'h0000);
        // A and B streaming together: alternating grants, no idle cycles
        vecs[6]  = mk(1, 1, 8'h11, 1, 2, 8'h22, 0,  1, 1, 0, 0, 8'h00, 16'h0000);
        vecs[7]  = mk(1, 1, 8'h11, 1, 2, 8'h22, 0,  1, 0, 1, 1, 8'h11, 16'h0006);
        vecs[8]  = mk(1, 1, 8'h11, 1, 2, 8'h22, 0,  0, 1, 1, 2, 8'h22, 16'h0006);
        vecs[9]  = mk(1, 1, 8'h11, 1, 2, 8'h22, 0,  1, 0, 1, 1, 8'h11, 16'h0006);
        vecs[10] = mk(1, 1, 8'h11, 1, 2, 8'h22, 0,  0, 1, 1, 2, 8'h22, 16'h0006);
        vecs[11] = mk(1, 1, 8'h11, 1, 2, 8'h22, 0,  1, 0, 1, 1, 8'h11, 16'h0006);
        vecs[12] = mk(0, 0, 8'h00, 1, 2, 8'h22, 0,  0, 1, 1, 2, 8'h22, 16'h0006);
        vecs[13] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  1, 0, 1, 1, 8'h11, 16'h0006);
        vecs[14] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  1, 1, 1, 2, 8'h22, 16'h0004);
        vecs[15] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  1, 1, 0, 0, 8'h00, 16'h0000);
        // Both slots full, wr_hold for 3 cycles, then two back-to-back writes
        vecs[16] = mk(1, 7, 8'h77, 1, 8, 8'h88, 0,  1, 1, 0, 0, 8'h00, 16'h0000);
        vecs[17] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 0, 0, 0, 8'h00, 16'h0180);
        vecs[18] = mk(1, 9, 8'h99, 0, 0, 8'h00, 1,  0, 0, 0, 0, 8'h00, 16'h0180);
        vecs[19] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 0, 0, 0, 8'h00, 16'h0180);
        vecs[20] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  1, 0, 1, 7, 8'h77, 16'h0180);
        vecs[21] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  1, 1, 1, 8, 8'h88, 16'h0100);
        vecs[22] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  1, 1, 0, 0, 8'h00, 16'h0000);
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int k = 0; k < N; k++) begin rf_obs[k] = '0; m_rf[k] = '0; end

        // Reset state, with A offering a write while reset is held
        drive(1, 4'd5, 8'hAB, 0, 0, 8'h00, 0);
        @(negedge CLK);
        #1;
        check_outs("reset", 1, 1, 0, 0, 8'h00, 16'h0000);
        $display("reset: we=%0b pend=%04h a_ready=%0b b_ready=%0b", reg_we, pend_mask, a_ready, b_ready);
        @(negedge CLK);
        drive(0, 0, 8'h00, 0, 0, 8'h00, 0);
        RST_N = 1'b1;

        for (int i = 0; i < NV; i++) begin
            cyc($sformatf("vec%0d", i), vecs[i].av, vecs[i].aa, vecs[i].ad,
                vecs[i].bv, vecs[i].ba, vecs[i].bd, vecs[i].hold,
                vecs[i].ar, vecs[i].br, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].pm);
        end

        // Same-address ordering: B loads first, A later with the pointer at A
        cyc("waw0", 0, 0, 8'h00, 1, 5, 8'h01, 1,  1, 1, 0, 0, 8'h00, 16'h0000);
        cyc("waw1", 1, 5, 8'h02, 0, 0, 8'h00, 1,  1, 0, 0, 0, 8'h00, 16'h0020);
        cyc("waw2", 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 1, 1, 5, 8'h01, 16'h0020);
        cyc("waw3", 0, 0, 8'h00, 0, 0, 8'h00, 0,  1, 1, 1, 5, 8'h02, 16'h0020);
        cyc("waw4", 0, 0, 8'h00, 0, 0, 8'h00, 0,  1, 1, 0, 0, 8'h00, 16'h0000);
        check("waw.reg5", 32'(rf_obs[5]), 32'h02);

        // Asynchronous reset while both slots are valid (pointer currently at B)
        cyc("rst0", 1, 9, 8'h91, 1, 10, 8'hA2, 1,  1, 1, 0, 0, 8'h00, 16'h0000);
        drive(0, 0, 8'h00, 0, 0, 8'h00, 1);
        #1;
        check_outs("rst1", 0, 0, 0, 0, 8'h00, 16'h0600);
        RST_N = 1'b0;
        #1;
        check_outs("rst_async", 1, 1, 0, 0, 8'h00, 16'h0000);
        $display("rst_async: we=%0b pend=%04h a_ready=%0b b_ready=%0b", reg_we, pend_mask, a_ready, b_ready);
        wr_hold = 1'b0;
        finish_cycle();
        #1;
        check_outs("rst_held", 1, 1, 0, 0, 8'h00, 16'h0000);
        RST_N = 1'b1;
        finish_cycle();
        cyc("rst_post0", 1, 3, 8'h33, 1, 4, 8'h44, 0,  1, 1, 0, 0, 8'h00, 16'h0000);
        cyc("rst_post1", 0, 0, 8'h00, 0, 0, 8'h00, 0,  1, 0, 1, 3, 8'h33, 16'h0018);
        cyc("rst_post2", 0, 0, 8'h00, 0, 0, 8'h00, 0,  1, 1, 1, 4, 8'h44, 16'h0010);
        cyc("rst_post3", 0, 0, 8'h00, 0, 0, 8'h00, 0,  1, 1, 0, 0, 8'h00, 16'h0000);

        // ---------------- randomized run against the reference model ----------------
        RST_N = 1'b0;
        drive(0, 0, 8'h00, 0, 0, 8'h00, 0);
        #1;
        finish_cycle();
        RST_N = 1'b1;
        model_reset();
        for (int k = 0; k < N; k++) begin rf_obs[k] = '0; m_rf[k] = '0; end

        for (int c = 0; c < 800; c++) begin
            logic         av, bv, hold;
            logic [D-1:0] aa, ba;
            logic [W-1:0] ad, bd;
            int           g;
            logic         ear, ebr;
            logic [D-1:0] ewa;
            logic [W-1:0] ewd;
            logic [N-1:0] epm;

            av   = ($urandom_range(0, 3) != 0);
            bv   = ($urandom_range(0, 3) != 0);
            // Narrow address range most of the time to provoke collisions and register 0
            aa   = ($urandom_range(0, 3) == 0) ? D'($urandom_range(0, N - 1)) : D'($urandom_range(0, 3));
            ba   = ($urandom_range(0, 3) == 0) ? D'($urandom_range(0, N - 1)) : D'($urandom_range(0, 3));
            ad   = W'($urandom);
            bd   = W'($urandom);
            hold = ($urandom_range(0, 4) == 0);

            drive(av, aa, ad, bv, ba, bd, hold);
            #1;

            g   = m_grant(hold);
            ear = !m_v[0] || (g == 0);
            ebr = !m_v[1] || (g == 1);
            ewa = (g >= 0) ? m_a[g] : '0;
            ewd = (g >= 0) ? m_d[g] : '0;
            epm = '0;
            for (int k = 0; k < 2; k++) if (m_v[k]) epm[m_a[k]] = 1'b1;

            check_outs($sformatf("rnd%0d", c), ear, ebr, (g >= 0), ewa, ewd, epm);
            $display("rnd%0d: a=%0b/%0h/%0h b=%0b/%0h/%0h hold=%0b -> we=%0b waddr=%0h wdata=%0h pend=%04h",
                     c, av, aa, ad, bv, ba, bd, hold, reg_we, reg_waddr, reg_wdata, pend_mask);

            // Advance the model across the clock edge
            if (g >= 0) begin
                m_rf[m_a[g]] = m_d[g];
                m_v[g]       = 1'b0;
                m_last       = g;
            end
            if (av && ear && aa != '0) begin
                m_v[0] = 1'b1; m_a[0] = aa; m_d[0] = ad; m_stamp[0] = m_seq; m_seq++;
            end
            if (bv && ebr && ba != '0) begin
                m_v[1] = 1'b1; m_a[1] = ba; m_d[1] = bd; m_stamp[1] = m_seq; m_seq++;
            end

            finish_cycle();
        end

        // Drain and compare the final register-file contents
        drive(0, 0, 8'h00, 0, 0, 8'h00, 0);
        #1;
        finish_cycle();
        #1;
        finish_cycle();
        for (int k = 0; k < 2; k++) begin
            if (m_v[k]) begin m_rf[m_a[k]] = m_d[k]; m_v[k] = 1'b0; end
        end
        for (int k = 1; k < N; k++) begin
            check($sformatf("rf[%0d]", k), 32'(rf_obs[k]), 32'(m_rf[k]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameter W, default 8, data width of one register.
REQ-002 Parameter D, default 4, register address width; register file depth is 2**D.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 a_valid  input  1  requester A (ALU writeback) offers a write.
REQ-006 a_ready  output  1  A's offer is accepted on a rising edge when a_valid && a_ready.
REQ-007 a_addr  input  D  A destination register; a_data  input  W  A write data.
REQ-008 b_valid, b_ready, b_addr, b_data: same as REQ-005..007 for requester B (load unit).
REQ-009 wr_hold  input  1  when high, no grant is issued this cycle.
REQ-010 reg_we  output  1  write enable to the shared register-file write port.
REQ-011 reg_waddr  output  D  write address; reg_wdata  output  W  write data.
REQ-012 pend_mask  output  2**D  bit k high when a buffered, not-yet-written entry targets register k.

Function
REQ-013 Each requester SHALL own a one-entry holding slot: valid bit, address, data.
REQ-014 x_ready SHALL be high when slot x is empty, or when slot x is granted in the current cycle (same-cycle refill).
REQ-015 An accepted request with address 0 SHALL be discarded: the slot is not loaded and no write occurs, matching the read-as-zero register 0.
REQ-016 Grant SHALL be combinational from the slot registers; at most one slot is granted per cycle; no grant while wr_hold is high.
REQ-017 Both slots valid, different addresses: grant SHALL follow a round-robin pointer; the pointer moves to the non-granted port after every grant.
REQ-018 Both slots valid, same address: the older slot SHALL be granted regardless of the pointer; the pointer then updates as in REQ-017.
REQ-019 Age SHALL be tracked by one flag: a slot loaded while the other is valid is younger; when both slots load on the same edge, A is older.
REQ-020 A granted slot SHALL empty on the next edge, unless it is refilled on that same edge per REQ-014.
REQ-021 reg_we SHALL equal "a grant is issued"; reg_waddr/reg_wdata SHALL carry the granted slot's contents; both are zero when reg_we is low.
REQ-022 Latency: a request accepted at edge N SHALL at the earliest appear on reg_we during the cycle after N, so the register file commits at edge N+1.
REQ-023 A single valid slot SHALL be granted in the next cycle without hold, irrespective of the pointer.
REQ-024 pend_mask SHALL be the OR of one-hot(addr) over valid slots; the bit for a granted slot stays set until its slot empties.
REQ-025 Sustained throughput SHALL be one write per cycle with no idle cycle while any slot is valid and wr_hold is low.

Reset
REQ-026 While RST_N is low: both slots empty, the pointer selects A, and A is the older slot.
REQ-027 Outputs during reset: reg_we=0, reg_waddr=0, reg_wdata=0, pend_mask=0, a_ready=1, b_ready=1.
REQ-028 Reset asserted mid-operation SHALL drop buffered entries without issuing a write; the first acceptance after RST_N rises behaves as from power-up.

Structure
REQ-029 Shared package SHALL hold defaults W=8 and D=4, the requester index enum {REQ_A, REQ_B}, and a slot struct {valid, addr, data}.
REQ-030 One sub-module is natural: wb_slot (one-entry holding register with load/clear), instantiated once per requester.
REQ-031 The arbiter SHALL connect to the existing register file through write_en/waddr/data_in only; read ports are untouched.

Verification
REQ-032 Reset -> release; A writes addr 3 data 0x5A -> reg_we=1, waddr=3, wdata=0x5A one cycle later; pend_mask bit3 high exactly for that cycle.
REQ-033 A (addr 1, 0x11) and B (addr 2, 0x22) presented on the same edge, repeated 4 times -> grants alternate A,B,A,B...; no idle cycles; a_ready and b_ready toggle accordingly.
REQ-034 B loads addr 5 = 0x01, then A loads addr 5 = 0x02 with the pointer at A -> B is written first, then A; final register 5 = 0x02.
REQ-035 A presents addr 0, data 0xFF -> a_ready=1, no reg_we, pend_mask stays 0.
REQ-036 Both slots full, wr_hold=1 for 3 cycles -> no writes, a_ready=b_ready=0, pend_mask stable; after release, two writes on consecutive cycles.
REQ-037 RST_N pulsed low while both slots are valid -> no write issued; outputs match REQ-027 immediately (asynchronously); normal operation resumes after release.
